hough_accum_sequencer: RTL and testbench
========================================

Name: hough_accum_sequencer

Overview:
- Top-level control FSM for the Hough accumulator datapath. Sequences one frame through CLEAR (zero accum_buff BRAM), VOTE (edge pixels from the mask/Canny stage), DRAIN (flush the vote pipeline) and SCAN (row-by-row readout to the peak finder).
- Generates all BRAM/datapath enables, indices and lane masks. The Hough datapath does the arithmetic; this block only schedules it.

Parameters:
- WIDTH, 1280, image width in pixels.
- HEIGHT, 720, image height in pixels.
- THETAS, 180, theta bins.
- RHOS, 1179, rho offset; RHO_RANGE = 2*RHOS = 2358 rows.
- THETA_UNROLL, 16, theta lanes per BRAM word.
- THETA_BITS, 9, theta index width.
- PIPE_DEPTH, 4, vote read-modify-write latency in cycles. Must satisfy 1 <= PIPE_DEPTH < NGROUPS, else elaboration $error.
- Derived: NGROUPS = ceil(THETAS/THETA_UNROLL) = 12; WORDS = RHO_RANGE*NGROUPS = 28296.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- start  in  1  one-cycle pulse; begins a frame (ignored unless IDLE or DONE)
- pix_valid  in  1  edge pixel available
- pix_ready  out  1  sequencer accepts pixel this cycle
- pix_x  in  11  pixel column
- pix_y  in  10  pixel row
- pix_last  in  1  marks final pixel of frame (may accompany a valid pixel)
- clear_en  out  1  write zero word
- clear_addr  out  15  word address being zeroed
- vote_en  out  1  datapath performs vote for (vote_x, vote_y, group)
- vote_x  out  11  latched pixel column
- vote_y  out  10  latched pixel row
- group  out  4  current theta group (vote or scan)
- lane_mask  out  THETA_UNROLL  valid lanes of current group (bit k valid if group*16+k < THETAS)
- scan_en  out  1  read word (scan_rho, group)
- scan_rho  out  12  rho row index 0..RHO_RANGE-1
- row_end  out  1  bubble cycle after each scanned row
- accum_buff_done  out  1  level; high from SCAN entry until next start
- busy  out  1  high in any state except IDLE and DONE

Behaviour:
- Reset: state=IDLE. All outputs 0 (pix_ready=0, all indices 0, accum_buff_done=0). Reset mid-frame aborts immediately; no partial state survives.
- IDLE/DONE: on start -> CLEAR, counters zeroed, accum_buff_done cleared.
- CLEAR: clear_en=1 for exactly WORDS cycles, clear_addr 0..WORDS-1 ascending, then -> VOTE. pix_ready=0 throughout.
- VOTE sub-phases:
  - Accept: pix_ready=1 only when no pixel is held. On pix_valid&&pix_ready, latch x/y (and pix_last).
  - Vote: starting the next cycle, vote_en=1 for NGROUPS cycles with group 0..11 and lane_mask=16'hFFFF, except group 11 uses 16'h000F.
  - pix_ready rises again in the cycle after group 11. Throughput is one pixel per NGROUPS+1 cycles.
- pix_last with pix_valid: that pixel is voted, then -> DRAIN.
- pix_last without pix_valid: -> DRAIN directly; no vote.
- pix_valid while pix_ready=0: held by the producer, not dropped.
- Hazard rule: the same (rho, group) word is revisited no sooner than NGROUPS+1 cycles, which exceeds PIPE_DEPTH, so no stall logic is needed.
- DRAIN: PIPE_DEPTH idle cycles, all enables 0, then -> SCAN.
- SCAN: accum_buff_done=1 from the first SCAN cycle.
  - For scan_rho 0..RHO_RANGE-1: NGROUPS cycles with scan_en=1, group 0..11 and lane_mask as in VOTE, then one cycle with scan_en=0 and row_end=1.
  - Total (NGROUPS+1)*RHO_RANGE = 30654 cycles, then -> DONE.
  - Read data is the datapath's responsibility and appears one cycle after scan_en.
- DONE: busy=0, accum_buff_done held 1. A start restarts at CLEAR.
- start in any busy state is ignored.
- Counters saturate at terminal values, never wrap. scan_rho is unsigned; the datapath subtracts RHOS for signed rho.

Test Plan:
- Reset/clear: reset, start -> clear_en high exactly 28296 cycles; clear_addr goes 0 then 28295; pix_ready 0 throughout.
- Single pixel: pix_valid with x=640, y=360, pix_last=1 -> 12 vote_en cycles, group 0..11, lane_mask FFFF x11 then 000F; 4 drain cycles; SCAN entered; accum_buff_done rises.
- Back-to-back pixels: pix_valid held high for 3 pixels -> pix_ready pulses every 13 cycles; vote_x/vote_y match each pixel in order; none dropped.
- Scan timing: after SCAN entry -> row_end on cycles 12, 25, ...; final scan_rho=2357; DONE after exactly 30654 SCAN cycles; busy falls.
- Empty frame: pix_last=1 with pix_valid=0 at first VOTE cycle -> zero vote_en cycles; DRAIN then SCAN proceed normally.
- Reset mid-SCAN: assert reset at scan_rho=1000 -> all outputs 0 and state IDLE immediately; a subsequent start repeats the full CLEAR.

Source files
------------

// File: rtl/hough_accum_sequencer.sv
// Hough accumulator frame sequencer.
//
// Walks one frame through CLEAR -> VOTE -> DRAIN -> SCAN -> DONE and drives every enable, index
// and lane mask the accumulator datapath needs. No arithmetic is done here.
//
// Ports:
//   clock, reset        system clock, asynchronous active-high reset
//   start               one-cycle frame start (honoured only in IDLE or DONE)
//   pix_valid/pix_ready edge-pixel handshake; pix_x/pix_y/pix_last travel with pix_valid
//   clear_en/clear_addr zero one accumulator word per cycle
//   vote_en             vote pixel (vote_x, vote_y) into theta group `group`
//   scan_en/scan_rho    read accumulator word (scan_rho, group) for the peak finder
//   row_end             bubble cycle after each scanned rho row
//   lane_mask           valid theta lanes of the current group
//   accum_buff_done     level, high from SCAN entry until the next start
//   busy                high in every state except IDLE and DONE
// All outputs are registered.
module hough_accum_sequencer #(
  parameter int unsigned WIDTH        = 1280,
  parameter int unsigned HEIGHT       = 720,
  parameter int unsigned THETAS       = 180,
  parameter int unsigned RHOS         = 1179,
  parameter int unsigned THETA_UNROLL = 16,
  parameter int unsigned THETA_BITS   = 9,
  parameter int unsigned PIPE_DEPTH   = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    pix_valid,
  output logic                    pix_ready,
  input  logic [10:0]             pix_x,
  input  logic [9:0]              pix_y,
  input  logic                    pix_last,
  output logic                    clear_en,
  output logic [14:0]             clear_addr,
  output logic                    vote_en,
  output logic [10:0]             vote_x,
  output logic [9:0]              vote_y,
  output logic [3:0]              group,
  output logic [THETA_UNROLL-1:0] lane_mask,
  output logic                    scan_en,
  output logic [11:0]             scan_rho,
  output logic                    row_end,
  output logic                    accum_buff_done,
  output logic                    busy
);

  localparam int unsigned NGROUPS   = (THETAS + THETA_UNROLL - 1) / THETA_UNROLL;
  localparam int unsigned RHO_RANGE = 2 * RHOS;
  localparam int unsigned WORDS     = RHO_RANGE * NGROUPS;

  localparam logic [14:0] ClearLast = 15'(WORDS - 1);
  localparam logic [3:0]  GroupLast = 4'(NGROUPS - 1);
  localparam logic [11:0] RhoLast   = 12'(RHO_RANGE - 1);
  localparam logic [3:0]  DrainLast = 4'(PIPE_DEPTH - 1);

  // A word is revisited every NGROUPS+1 cycles; that must outlast the RMW pipeline.
  if (PIPE_DEPTH < 1 || PIPE_DEPTH >= NGROUPS) begin : g_bad_pipe_depth
    $error("PIPE_DEPTH must satisfy 1 <= PIPE_DEPTH < NGROUPS");
  end
  if (NGROUPS > 16 || WORDS > 32768 || RHO_RANGE > 4096) begin : g_bad_index_width
    $error("Group, address or rho index does not fit its port width");
  end
  if (WIDTH > 2048 || HEIGHT > 1024 || THETAS > (1 << THETA_BITS)) begin : g_bad_geometry
    $error("Image or theta geometry does not fit the index widths");
  end

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StVote,
    StDrain,
    StScan,
    StDone
  } state_e;

  state_e                  state_q;
  logic                    pix_ready_q;
  logic                    clear_en_q;
  logic [14:0]             clear_addr_q;
  logic                    vote_en_q;
  logic [10:0]             vote_x_q;
  logic [9:0]              vote_y_q;
  logic                    last_q;
  logic [3:0]              group_q;
  logic [THETA_UNROLL-1:0] lane_mask_q;
  logic                    scan_en_q;
  logic [11:0]             scan_rho_q;
  logic                    row_end_q;
  logic                    done_q;
  logic                    busy_q;
  logic [3:0]              drain_q;

  // Lane k of group g is a real theta bin only while g*THETA_UNROLL+k < THETAS.
  function automatic logic [THETA_UNROLL-1:0] mask_for(input logic [3:0] g);
    logic [THETA_UNROLL-1:0] m;
    m = '0;
    for (int unsigned k = 0; k < THETA_UNROLL; k++) begin
      m[k] = (({28'd0, g} * THETA_UNROLL) + k) < THETAS;
    end
    return m;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      pix_ready_q  <= 1'b0;
      clear_en_q   <= 1'b0;
      clear_addr_q <= '0;
      vote_en_q    <= 1'b0;
      vote_x_q     <= '0;
      vote_y_q     <= '0;
      last_q       <= 1'b0;
      group_q      <= '0;
      lane_mask_q  <= '0;
      scan_en_q    <= 1'b0;
      scan_rho_q   <= '0;
      row_end_q    <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      drain_q      <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q      <= StClear;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            clear_en_q   <= 1'b1;
            clear_addr_q <= '0;
            pix_ready_q  <= 1'b0;
            vote_en_q    <= 1'b0;
            vote_x_q     <= '0;
            vote_y_q     <= '0;
            last_q       <= 1'b0;
            group_q      <= '0;
            lane_mask_q  <= '0;
            scan_en_q    <= 1'b0;
            scan_rho_q   <= '0;
            row_end_q    <= 1'b0;
            drain_q      <= '0;
          end
        end

        StClear: begin
          if (clear_addr_q == ClearLast) begin
            // Address saturates at the last word; accept the first pixel next cycle.
            clear_en_q  <= 1'b0;
            pix_ready_q <= 1'b1;
            state_q     <= StVote;
          end else begin
            clear_addr_q <= clear_addr_q + 15'd1;
          end
        end

        StVote: begin
          if (vote_en_q) begin
            if (group_q == GroupLast) begin
              vote_en_q   <= 1'b0;
              lane_mask_q <= '0;
              if (last_q) begin
                state_q <= StDrain;
                drain_q <= '0;
              end else begin
                pix_ready_q <= 1'b1;
              end
            end else begin
              group_q     <= group_q + 4'd1;
              lane_mask_q <= mask_for(group_q + 4'd1);
            end
          end else if (pix_ready_q) begin
            if (pix_valid) begin
              vote_x_q    <= pix_x;
              vote_y_q    <= pix_y;
              last_q      <= pix_last;
              vote_en_q   <= 1'b1;
              group_q     <= '0;
              lane_mask_q <= mask_for(4'd0);
              pix_ready_q <= 1'b0;
            end else if (pix_last) begin
              // End of frame with no pixel attached: nothing to vote.
              pix_ready_q <= 1'b0;
              state_q     <= StDrain;
              drain_q     <= '0;
            end
          end
        end

        StDrain: begin
          if (drain_q == DrainLast) begin
            state_q     <= StScan;
            done_q      <= 1'b1;
            scan_en_q   <= 1'b1;
            scan_rho_q  <= '0;
            group_q     <= '0;
            lane_mask_q <= mask_for(4'd0);
          end else begin
            drain_q <= drain_q + 4'd1;
          end
        end

        StScan: begin
          if (scan_en_q) begin
            if (group_q == GroupLast) begin
              scan_en_q   <= 1'b0;
              row_end_q   <= 1'b1;
              lane_mask_q <= '0;
            end else begin
              group_q     <= group_q + 4'd1;
              lane_mask_q <= mask_for(group_q + 4'd1);
            end
          end else if (row_end_q) begin
            row_end_q <= 1'b0;
            if (scan_rho_q == RhoLast) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
            end else begin
              scan_rho_q  <= scan_rho_q + 12'd1;
              group_q     <= '0;
              lane_mask_q <= mask_for(4'd0);
              scan_en_q   <= 1'b1;
            end
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign pix_ready       = pix_ready_q;
  assign clear_en        = clear_en_q;
  assign clear_addr      = clear_addr_q;
  assign vote_en         = vote_en_q;
  assign vote_x          = vote_x_q;
  assign vote_y          = vote_y_q;
  assign group           = group_q;
  assign lane_mask       = lane_mask_q;
  assign scan_en         = scan_en_q;
  assign scan_rho        = scan_rho_q;
  assign row_end         = row_end_q;
  assign accum_buff_done = done_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_hough_accum_sequencer.sv
// Bench for hough_accum_sequencer. A full-size instance checks the CLEAR length at the default
// geometry; a reduced-rho instance runs complete frames (vote, drain, scan, reset mid-scan).
module tb_hough_accum_sequencer;

  localparam int NG     = 12;
  localparam int PD     = 4;
  localparam int S_RHOS = 8;
  localparam int S_RNG  = 2 * S_RHOS;
  localparam int S_WRDS = S_RNG * NG;
  localparam int S_SCAN = (NG + 1) * S_RNG;
  localparam int B_WRDS = 28296;

  logic clock;
  int   cyc;
  int   n_cmp;
  int   n_err;
  int   n_votes;
  int   prev_hs;

  // Reduced-rho instance.
  logic        reset, start, pix_valid, pix_last;
  logic [10:0] pix_x;
  logic [9:0]  pix_y;
  logic        pix_ready, clear_en, vote_en, scan_en, row_end, accum_buff_done, busy;
  logic [14:0] clear_addr;
  logic [10:0] vote_x;
  logic [9:0]  vote_y;
  logic [3:0]  group;
  logic [15:0] lane_mask;
  logic [11:0] scan_rho;

  // Default-geometry instance.
  logic        reset_b, start_b, pix_valid_b, pix_last_b;
  logic [10:0] pix_x_b;
  logic [9:0]  pix_y_b;
  logic        pix_ready_b, clear_en_b, vote_en_b, scan_en_b, row_end_b, done_b, busy_b;
  logic [14:0] clear_addr_b;
  logic [10:0] vote_x_b;
  logic [9:0]  vote_y_b;
  logic [3:0]  group_b;
  logic [15:0] lane_mask_b;
  logic [11:0] scan_rho_b;

  hough_accum_sequencer #(.RHOS(S_RHOS)) u_dut (
    .clock(clock), .reset(reset), .start(start),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y),
    .pix_last(pix_last), .clear_en(clear_en), .clear_addr(clear_addr), .vote_en(vote_en),
    .vote_x(vote_x), .vote_y(vote_y), .group(group), .lane_mask(lane_mask),
    .scan_en(scan_en), .scan_rho(scan_rho), .row_end(row_end),
    .accum_buff_done(accum_buff_done), .busy(busy)
  );

  hough_accum_sequencer u_dut_full (
    .clock(clock), .reset(reset_b), .start(start_b),
    .pix_valid(pix_valid_b), .pix_ready(pix_ready_b), .pix_x(pix_x_b), .pix_y(pix_y_b),
    .pix_last(pix_last_b), .clear_en(clear_en_b), .clear_addr(clear_addr_b),
    .vote_en(vote_en_b), .vote_x(vote_x_b), .vote_y(vote_y_b), .group(group_b),
    .lane_mask(lane_mask_b), .scan_en(scan_en_b), .scan_rho(scan_rho_b), .row_end(row_end_b),
    .accum_buff_done(done_b), .busy(busy_b)
  );

  typedef struct {
    logic        valid;
    logic [10:0] x;
    logic [9:0]  y;
    logic        last;
    int          exp_votes;
    int          exp_interval;  // 0: no handshake spacing check
  } vec_t;

  typedef struct {
    logic [10:0] x;
    logic [9:0]  y;
    logic [3:0]  g;
    logic [15:0] m;
  } vote_t;

  vec_t  vecs[7];
  vote_t sb[$];
  vote_t mon_e;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  function automatic void check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [15:0] exp_mask(input int g);
    return (g == 11) ? 16'h000F : 16'hFFFF;
  endfunction

  // Scoreboard: every vote cycle must match the next expected (x, y, group, mask).
  always @(negedge clock) begin
    if (vote_en) begin
      n_votes++;
      check("vote_expected", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        check("vote_x", vote_x, mon_e.x);
        check("vote_y", vote_y, mon_e.y);
        check("vote_group", group, mon_e.g);
        check("vote_lane_mask", lane_mask, mon_e.m);
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_pix_ready"}, pix_ready, 0);
    check({tag, "_enables"}, {clear_en, vote_en, scan_en, row_end}, 0);
    check({tag, "_clear_addr"}, clear_addr, 0);
    check({tag, "_vote_xy"}, {vote_x, vote_y}, 0);
    check({tag, "_group"}, group, 0);
    check({tag, "_lane_mask"}, lane_mask, 0);
    check({tag, "_scan_rho"}, scan_rho, 0);
    check({tag, "_done"}, accum_buff_done, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  // Present one vector and hold it until the sequencer takes it.
  task automatic drive_vec(input vec_t v, output int hs);
    pix_valid = v.valid;
    pix_x     = v.x;
    pix_y     = v.y;
    pix_last  = v.last;
    hs        = -1000;
    for (int t = 0; t < 40; t++) begin
      if (pix_ready) begin
        hs = cyc;
        break;
      end
      @(negedge clock);
    end
    check("pix_ready_seen", pix_ready, 1);
    if (pix_ready) begin
      if (v.valid) begin
        for (int g = 0; g < NG; g++) sb.push_back('{v.x, v.y, 4'(g), exp_mask(g)});
      end
      if (v.exp_interval != 0) check("pix_ready_interval", hs - prev_hs, v.exp_interval);
      prev_hs = hs;
      @(negedge clock);
    end
  endtask

  task automatic run_frame(input int first, input int last, input int abort_rho, input bit poke);
    int cnt, first_addr, last_addr, hs, exp_scan, votes_exp, pre_done, scan_err, last_rho;
    int rho, pos;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("done_cleared_on_start", accum_buff_done, 0);

    cnt = 0; first_addr = -1; last_addr = -1;
    for (int i = 0; i < S_WRDS + 20; i++) begin
      if (pix_ready) break;
      if (clear_en) begin
        if (cnt == 0) first_addr = clear_addr;
        last_addr = clear_addr;
        cnt++;
      end
      @(negedge clock);
    end
    check("clear_done_ready", pix_ready, 1);
    check("clear_cycles", cnt, S_WRDS);
    check("clear_first_addr", first_addr, 0);
    check("clear_last_addr", last_addr, S_WRDS - 1);
    check("clear_en_off_in_vote", clear_en, 0);

    n_votes = 0; votes_exp = 0; prev_hs = 0; exp_scan = 0; hs = 0;
    for (int i = first; i <= last; i++) begin
      drive_vec(vecs[i], hs);
      votes_exp += vecs[i].exp_votes;
      if (i == last) exp_scan = hs + (vecs[i].valid ? NG : 0) + PD + 1;
    end
    pix_valid = 1'b0;
    pix_last  = 1'b0;

    pre_done = 0;
    for (int i = 0; i < 40; i++) begin
      if (scan_en) break;
      if (accum_buff_done || vote_en && cyc > exp_scan - PD - 1) pre_done++;
      @(negedge clock);
    end
    check("scan_entered", scan_en, 1);
    check("scan_entry_cycle", cyc, exp_scan);
    check("drain_quiet", pre_done, 0);
    check("vote_count", n_votes, votes_exp);
    check("scoreboard_empty", sb.size(), 0);
    check("done_at_scan_entry", accum_buff_done, 1);

    scan_err = 0; last_rho = -1;
    for (int c = 0; c < S_SCAN; c++) begin
      rho = c / (NG + 1);
      pos = c % (NG + 1);
      if (abort_rho >= 0 && rho == abort_rho && pos == 0) begin
        check("abort_rho_reached", scan_rho, abort_rho);
        reset = 1'b1;
        #1;
        check_all_zero("reset_mid_scan");
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("idle_after_reset_busy", busy, 0);
        check("idle_after_reset_scan", scan_en, 0);
        return;
      end
      if (poke) start = (c == 50);
      if (scan_en !== (pos < NG) || row_end !== (pos == NG) || scan_rho !== 12'(rho) ||
          (pos < NG && (group !== 4'(pos) || lane_mask !== exp_mask(pos))) ||
          vote_en || clear_en || pix_ready || !accum_buff_done || !busy) begin
        scan_err++;
      end
      if (scan_en) last_rho = scan_rho;
      @(negedge clock);
    end
    start = 1'b0;
    check("scan_sequence_errors", scan_err, 0);
    check("scan_last_rho", last_rho, S_RNG - 1);
    check("done_busy_low", busy, 0);
    check("done_flag_held", accum_buff_done, 1);
    check("done_enables_low", {scan_en, row_end, vote_en, clear_en, pix_ready}, 0);
  endtask

  initial begin
    int cnt, first_addr, last_addr, bad;
    n_cmp = 0; n_err = 0; n_votes = 0; prev_hs = 0; cyc = 0;
    reset = 1'b0; start = 1'b0; pix_valid = 1'b0; pix_last = 1'b0; pix_x = '0; pix_y = '0;
    reset_b = 1'b0; start_b = 1'b0; pix_valid_b = 1'b0; pix_last_b = 1'b0;
    pix_x_b = '0; pix_y_b = '0;

    vecs[0] = '{1'b0, 11'd0,    10'd0,   1'b1, 0,  0};   // empty frame
    vecs[1] = '{1'b1, 11'd640,  10'd360, 1'b1, 12, 0};   // single pixel
    vecs[2] = '{1'b1, 11'd10,   10'd20,  1'b0, 12, 0};   // back-to-back x3
    vecs[3] = '{1'b1, 11'd1279, 10'd719, 1'b0, 12, 13};
    vecs[4] = '{1'b1, 11'd0,    10'd0,   1'b1, 12, 13};
    vecs[5] = '{1'b1, 11'd5,    10'd6,   1'b0, 12, 0};   // pixel, then bare last
    vecs[6] = '{1'b0, 11'd0,    10'd0,   1'b1, 0,  13};

    #1;
    reset = 1'b1; reset_b = 1'b1;
    #1;
    check_all_zero("reset");
    repeat (2) @(negedge clock);
    check_all_zero("reset_held");

    // Full-size CLEAR length and addressing.
    reset_b = 1'b0;
    @(negedge clock);
    start_b = 1'b1;
    @(negedge clock);
    start_b = 1'b0;
    cnt = 0; first_addr = -1; last_addr = -1; bad = 0;
    for (int i = 0; i < B_WRDS + 20; i++) begin
      if (clear_en_b) begin
        if (cnt == 0) first_addr = clear_addr_b;
        last_addr = clear_addr_b;
        cnt++;
        if (pix_ready_b) bad++;
      end
      if (pix_ready_b) break;
      @(negedge clock);
    end
    check("full_clear_cycles", cnt, B_WRDS);
    check("full_clear_first_addr", first_addr, 0);
    check("full_clear_last_addr", last_addr, B_WRDS - 1);
    check("full_ready_during_clear", bad, 0);
    check("full_vote_ready", pix_ready_b, 1);
    check("full_busy_in_vote", busy_b, 1);
    reset_b = 1'b1;

    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("idle_busy", busy, 0);

    run_frame(0, 0, -1, 1'b0);   // empty frame from IDLE
    run_frame(1, 1, -1, 1'b1);   // single pixel from DONE; start poked during SCAN
    run_frame(2, 4, -1, 1'b0);   // back-to-back pixels
    run_frame(5, 6, 10, 1'b0);   // reset at scan_rho 10
    run_frame(1, 1, -1, 1'b0);   // full frame again after reset

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
